mac_accum_tree: RTL and testbench
=================================

// Module: mac_accum_tree
// PURPOSE
//  Consumer end of the array partial-product interface. Reduces the 16 per-bank
//  8-bit partial products (add0..add15) of each bit-serial input plane with a
//  registered adder tree, then shift-accumulates planes (MSB first) into one MAC
//  result. In search mode it captures the 16 per-bank match bits and their
//  popcount. The result is offered to the downstream controller via valid/ready.
// PARAMETERS
//  NBANK   16   number of bank partial-product lanes (fixed at 16 for this array)
//  IN_W    8    width of each partial product
//  BITS    8    number of input bit-planes per MAC operation (>=1)
//  ACC_W   20   accumulator width; must be >= IN_W+4+BITS (no overflow by design)
// PORTS
//  clk        in   1              system clock, all logic on rising edge
//  rst        in   1              synchronous reset, active-high
//  start      in   1              pulse: begin operation (accepted only in IDLE)
//  mac_en     in   1              mode sampled with start: 1=MAC, 0=search
//  in_valid   in   1              add_bus holds a valid plane this cycle
//  add_bus    in   NBANK*IN_W     packed partial products, add0 at [7:0], add15 at [127:120]
//  busy       out  1              high in every state except IDLE
//  out_valid  out  1              result valid, held until out_ready
//  out_ready  in   1              downstream accepts result
//  acc_out    out  ACC_W          MAC result, or popcount of matches in search mode
//  match_out  out  NBANK          search-mode match vector (bit i = add_i[0]); 0 in MAC mode
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE; busy=0, out_valid=0, acc_out=0,
//   match_out=0; plane counter, tree register, mode register cleared.
//   Reset mid-operation aborts it; no result is produced.
//  States: IDLE -> ACCUM -> DRAIN -> DONE -> IDLE.
//   IDLE : start=1 -> latch mode=mac_en, clear acc and plane count, go ACCUM.
//          in_valid ignored in IDLE, including the start cycle itself.
//   ACCUM: each cycle with in_valid=1 accepts one plane:
//          sum_q <= sum of 16 lanes (12 bits, zero-extended), plane_cnt++.
//          in_valid=0 inserts a bubble; nothing changes except sum_q_vld=0.
//          MAC: accept BITS planes; search: accept exactly 1 plane.
//          After the last plane is accepted -> DRAIN.
//   Accumulate stage (MAC, any state, when sum_q_vld): acc <= (acc<<1) + sum_q.
//          Planes arrive MSB first, so plane k (0-based) carries weight 2^(BITS-1-k).
//   Search plane: match_out <= {add15[0],...,add0[0]}; acc <= popcount (0..16),
//          latched one cycle after acceptance, same timing as MAC.
//   DRAIN: one cycle for the final accumulate -> DONE with out_valid=1.
//          Latency: last plane accepted at edge N, out_valid visible after N+2.
//   DONE : out_valid=1, acc_out/match_out stable. out_valid&out_ready -> IDLE,
//          out_valid drops at that edge; acc_out/match_out keep last value.
//  Widths: max MAC result = 16*(2^IN_W-1)*(2^BITS-1) = 0xFE010 for defaults (fits 20 bits).
//  start while busy (ACCUM/DRAIN/DONE) is ignored; start in the same cycle as
//   the DONE handshake is ignored (accepted only from IDLE next cycle).
//  in_valid outside ACCUM is ignored; no planes are buffered.
//  mac_en changes after start have no effect on the running operation.
// TESTING
//  1 MAC, all lanes 8'hFF, 8 back-to-back planes -> acc_out=20'hFE010, out_valid 2 cycles after last plane.
//  2 MAC, plane0 lane0=8'h01, all other planes/lanes 0 -> acc_out=128; planes 1..7 only lane0=1 -> acc_out=255.
//  3 MAC, all lanes 8'h01, planes with in_valid bubbles (1,0,1,0..) -> acc_out=0xFF0, same as no bubbles.
//  4 Search, lane bit0 pattern 16'hA5A5 -> match_out=16'hA5A5, acc_out=8; MAC run after -> match_out=0.
//  5 Hold out_ready=0 for 5 cycles in DONE with start pulses -> result stable, start ignored; ready=1 -> IDLE.
//  6 rst=1 during plane 4 of a MAC op -> next cycle busy=0, out_valid=0, acc_out=0; fresh op correct.

Source files
------------

// File: rtl/mac_accum_tree.sv
// Reduces 16 per-bank partial products per bit-plane and shift-accumulates planes (MSB first) into a MAC result, or captures match bits + popcount in search mode.
// Latency: last plane accepted at edge N -> result registered at N+1, out_valid visible after edge N+2.
// Backpressure: result and out_valid held in DONE until out_ready; no input buffering, in_valid ignored outside ACCUM.
module mac_accum_tree #(
    parameter int NBANK = 16,
    parameter int IN_W  = 8,
    parameter int BITS  = 8,
    parameter int ACC_W = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mac_en,
    input  logic                  in_valid,
    input  logic [NBANK*IN_W-1:0] add_bus,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      acc_out,
    output logic [NBANK-1:0]      match_out
);

    localparam int SUM_W = IN_W + $clog2(NBANK);
    localparam int CNT_W = $clog2(BITS + 1);
    localparam int PC_W  = $clog2(NBANK + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               mode_mac;
    logic [CNT_W-1:0]   plane_cnt;
    logic [SUM_W-1:0]   sum_q;
    logic               sum_q_vld;
    logic [NBANK-1:0]   match_q;

    logic [SUM_W-1:0]   lane_sum;
    logic [NBANK-1:0]   lane_bit0;
    logic [PC_W-1:0]    match_pop;
    logic               planes_done;
    logic               accept;

    // Plane count target depends on the latched mode: BITS planes for MAC, one for search.
    assign planes_done = mode_mac ? (plane_cnt == CNT_W'(BITS)) : (plane_cnt == CNT_W'(1));
    assign accept      = (state == ACCUM) && in_valid && !planes_done;
    assign busy        = (state != IDLE);
    assign out_valid   = (state == DONE);

    // Reduce all lanes of the current plane and pick off each lane's match bit.
    always_comb begin
        lane_sum  = '0;
        lane_bit0 = '0;
        for (int i = 0; i < NBANK; i++) begin
            lane_sum     = lane_sum + {{(SUM_W-IN_W){1'b0}}, add_bus[i*IN_W +: IN_W]};
            lane_bit0[i] = add_bus[i*IN_W];
        end
    end

    // Popcount of the registered match vector for the search result.
    always_comb begin
        match_pop = '0;
        for (int i = 0; i < NBANK; i++) begin
            match_pop = match_pop + {{(PC_W-1){1'b0}}, match_q[i]};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: DRAIN covers the cycle in which the final plane is accumulated.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)       state_nxt = ACCUM;
            ACCUM:   if (planes_done) state_nxt = DRAIN;
            DRAIN:                    state_nxt = DONE;
            DONE:    if (out_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Tree register, plane counter, mode latch and the shift-accumulate / search capture stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_mac  <= 1'b0;
            plane_cnt <= '0;
            sum_q     <= '0;
            sum_q_vld <= 1'b0;
            match_q   <= '0;
            acc_out   <= '0;
            match_out <= '0;
        end else begin
            sum_q_vld <= accept;
            if (accept) begin
                sum_q     <= lane_sum;
                match_q   <= lane_bit0;
                plane_cnt <= plane_cnt + CNT_W'(1);
            end
            if (state == IDLE && start) begin
                mode_mac  <= mac_en;
                plane_cnt <= '0;
                acc_out   <= '0;
                match_out <= '0;
            end else if (sum_q_vld) begin
                if (mode_mac) begin
                    acc_out <= {acc_out[ACC_W-2:0], 1'b0} + {{(ACC_W-SUM_W){1'b0}}, sum_q};
                end else begin
                    match_out <= match_q;
                    acc_out   <= {{(ACC_W-PC_W){1'b0}}, match_pop};
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_accum_tree.sv
module tb_mac_accum_tree;

    localparam int NB   = 16;
    localparam int IW   = 8;
    localparam int BITS = 8;
    localparam int AW   = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              mac_en;
    logic              in_valid;
    logic [NB*IW-1:0]  add_bus;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     acc_out;
    logic [NB-1:0]     match_out;

    mac_accum_tree #(.NBANK(NB), .IN_W(IW), .BITS(BITS), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .mac_en(mac_en), .in_valid(in_valid),
        .add_bus(add_bus), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .match_out(match_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0]    exp_acc;
    logic [NB-1:0]    exp_match;
    logic [NB*IW-1:0] planes [BITS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [NB*IW-1:0] rnd_bus();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: each plane's lane total weighted by 2^(BITS-1-k); search takes bit0 of each lane.
    task automatic model(input bit is_mac);
        int acc;
        int s;
        acc       = 0;
        exp_match = '0;
        if (is_mac) begin
            for (int k = 0; k < BITS; k++) begin
                s = 0;
                for (int i = 0; i < NB; i++) s += int'(planes[k][i*IW +: IW]);
                acc += s * (1 << (BITS - 1 - k));
            end
        end else begin
            for (int i = 0; i < NB; i++) exp_match[i] = planes[0][i*IW];
            acc = $countones(exp_match);
        end
        exp_acc = AW'(acc);
    endtask

    // Whenever a result is presented it must equal the model.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("acc_out", 32'(acc_out), 32'(exp_acc));
            check("match_out", 32'(match_out), 32'(exp_match));
        end
    end

    // bub < 0 : one bubble before every plane after the first; otherwise percent chance of bubbles.
    task automatic run_op(input bit is_mac, input int bub, input int hold, input bit start_in_hold);
        int n;
        n = is_mac ? BITS : 1;
        model(is_mac);
        out_ready = 1'b0;
        start     = 1'b1;
        mac_en    = is_mac;
        in_valid  = 1'b1;
        add_bus   = rnd_bus();
        @(posedge clk); #1;
        start  = 1'b0;
        mac_en = $urandom_range(1);
        check("busy_after_start", 32'(busy), 32'd1);
        for (int k = 0; k < n; k++) begin
            if (bub < 0) begin
                if (k > 0) begin
                    in_valid = 1'b0; add_bus = rnd_bus();
                    @(posedge clk); #1;
                end
            end else begin
                while ($urandom_range(99) < bub) begin
                    in_valid = 1'b0; add_bus = rnd_bus();
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            add_bus  = planes[k];
            @(posedge clk); #1;
        end
        // Extra valid plane after the last one must be ignored.
        add_bus = rnd_bus();
        @(negedge clk);
        check("out_valid_n0", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("out_valid_n1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("out_valid_n2", 32'(out_valid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            start = start_in_hold;
            @(posedge clk); #1;
            start = 1'b0;
            check("hold_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        start     = start_in_hold;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        check("hs_drop", 32'(out_valid), 32'd0);
        check("hs_idle", 32'(busy), 32'd0);
        check("acc_keep", 32'(acc_out), 32'(exp_acc));
        check("match_keep", 32'(match_out), 32'(exp_match));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mac_en = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; add_bus = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_acc", 32'(acc_out), 32'd0);
        check("rst_match", 32'(match_out), 32'd0);
        rst = 1'b0;
        // in_valid in IDLE without start does nothing
        in_valid = 1'b1; add_bus = rnd_bus();
        @(posedge clk); #1;
        check("idle_ignore", 32'(busy), 32'd0);
        in_valid = 1'b0;

        // 1: all lanes FF, back-to-back
        for (int k = 0; k < BITS; k++) planes[k] = {NB*IW{1'b1}};
        model(1'b1);
        check("model_t1", 32'(exp_acc), 32'hFE010);
        run_op(1'b1, 0, 0, 1'b0);
        check("t1_acc", 32'(acc_out), 32'hFE010);

        // 2a: only plane0 lane0 = 1
        for (int k = 0; k < BITS; k++) planes[k] = '0;
        planes[0][7:0] = 8'h01;
        run_op(1'b1, 0, 0, 1'b0);
        check("t2a_acc", 32'(acc_out), 32'd128);
        // 2b: lane0 = 1 in every plane
        for (int k = 0; k < BITS; k++) planes[k][7:0] = 8'h01;
        run_op(1'b1, 0, 1, 1'b0);
        check("t2b_acc", 32'(acc_out), 32'd255);

        // 3: all lanes 1 with alternating bubbles
        for (int k = 0; k < BITS; k++)
            for (int i = 0; i < NB; i++) planes[k][i*IW +: IW] = 8'h01;
        run_op(1'b1, -1, 0, 1'b0);
        check("t3_acc", 32'(acc_out), 32'hFF0);

        // 4: search with bit0 pattern A5A5, then MAC clears match_out
        planes[0] = rnd_bus();
        for (int i = 0; i < NB; i++) planes[0][i*IW] = (16'hA5A5 >> i) & 16'h1;
        model(1'b0);
        check("model_t4_match", 32'(exp_match), 32'hA5A5);
        check("model_t4_acc", 32'(exp_acc), 32'd8);
        run_op(1'b0, 0, 0, 1'b0);
        check("t4_match", 32'(match_out), 32'hA5A5);
        check("t4_acc", 32'(acc_out), 32'd8);
        for (int k = 0; k < BITS; k++) planes[k] = rnd_bus();
        run_op(1'b1, 0, 0, 1'b0);
        check("t4_mac_match", 32'(match_out), 32'd0);

        // 5: hold result 5 cycles with start pulses
        for (int k = 0; k < BITS; k++) planes[k] = rnd_bus();
        run_op(1'b1, 20, 5, 1'b1);

        // 6: reset during plane 4
        start = 1'b1; mac_en = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; add_bus = rnd_bus();
            @(posedge clk); #1;
        end
        add_bus = rnd_bus(); rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_acc", 32'(acc_out), 32'd0);
        check("t6_match", 32'(match_out), 32'd0);
        for (int k = 0; k < BITS; k++) planes[k] = rnd_bus();
        run_op(1'b1, 0, 0, 1'b0);

        // Random operations
        for (int t = 0; t < 40; t++) begin
            bit m;
            m = ($urandom_range(3) != 0);
            for (int k = 0; k < BITS; k++) planes[k] = rnd_bus();
            if ($urandom_range(7) == 0)
                for (int k = 0; k < BITS; k++) planes[k] = {NB*IW{1'b1}};
            run_op(m, 30, $urandom_range(3), $urandom_range(1));
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
